cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers: the RS/ALU path and the LSB.
- Each source writes into its own small result FIFO. A round-robin arbiter pops one entry per cycle into a registered CDB output, which the ROB, RS and LSB snoop.
- Replaces direct dual broadcast, so consumers watch one (rob_entry, value) pair per cycle.

---
 rtl/cdb_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Shares the common data bus between the RS/ALU result path and the LSB.
//   Each producer pushes into its own small circular FIFO; a round-robin
//   arbiter pops at most one head per cycle onto a registered CDB output.
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global freeze when low)
//   rob_clear_up                      : mispredict flush (empties FIFOs, clears CDB)
//   alu_valid/alu_rob_entry/alu_value : ALU result push, alu_full back-pressure
//   lsb_valid/lsb_rob_entry/lsb_value : LSB result push, lsb_full back-pressure
//   cdb_valid/cdb_rob_entry/cdb_value/cdb_src : registered broadcast (src 0=ALU, 1=LSB)
//   overflow_err                      : sticky, push seen while FIFO full
//
// Optional feature
//   CDB_ARB_BYPASS_EN : when defined, a push into an empty FIFO competes for the
//   bus in the same cycle and, if granted, skips the FIFO (1-cycle latency).
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear_up,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_entry,
  input  logic [31:0]      alu_value,
  output logic             alu_full,
  input  logic             lsb_valid,
  input  logic [ROB_W-1:0] lsb_rob_entry,
  input  logic [31:0]      lsb_value,
  output logic             lsb_full,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob_entry,
  output logic [31:0]      cdb_value,
  output logic             cdb_src,
  output logic             overflow_err
);

  localparam logic [FIFO_AW-1:0] PTR_ZERO = FIFO_AW'(1'b0);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1'b1);
  localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW+1)'(1'b0);
  localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1'b1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [ROB_W-1:0]   alu_tag_mem_r [FIFO_DEPTH];
  logic [31:0]        alu_val_mem_r [FIFO_DEPTH];
  logic [ROB_W-1:0]   lsb_tag_mem_r [FIFO_DEPTH];
  logic [31:0]        lsb_val_mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0] alu_rd_ptr_r, alu_wr_ptr_r, lsb_rd_ptr_r, lsb_wr_ptr_r;
  logic [FIFO_AW:0]   alu_cnt_r, lsb_cnt_r;
  logic               last_grant_r;

  logic alu_nonempty_s, lsb_nonempty_s;
  logic alu_bp_s, lsb_bp_s;
  logic alu_elig_s, lsb_elig_s;
  logic grant_alu_s, grant_lsb_s;
  logic alu_push_s, lsb_push_s, alu_pop_s, lsb_pop_s;
  logic [ROB_W-1:0] sel_tag_s;
  logic [31:0]      sel_val_s;
  logic             advance_s;

  assign alu_full       = (alu_cnt_r == CNT_FULL);
  assign lsb_full       = (lsb_cnt_r == CNT_FULL);
  assign alu_nonempty_s = (alu_cnt_r != CNT_ZERO);
  assign lsb_nonempty_s = (lsb_cnt_r != CNT_ZERO);

  // Bypass candidates: a fresh push into an empty FIFO may compete this cycle.
`ifdef CDB_ARB_BYPASS_EN
  assign alu_bp_s = alu_valid & ~alu_nonempty_s;
  assign lsb_bp_s = lsb_valid & ~lsb_nonempty_s;
`else
  assign alu_bp_s = 1'b0;
  assign lsb_bp_s = 1'b0;
`endif

  assign alu_elig_s = alu_nonempty_s | alu_bp_s;
  assign lsb_elig_s = lsb_nonempty_s | lsb_bp_s;

  // Normal-operation edge: not in reset, not flushing, not frozen.
  assign advance_s = rst_in & ~rob_clear_up & rdy_in;

  // Round-robin grant: on a tie the source opposite last_grant wins.
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsb_s = 1'b0;
    if (alu_elig_s && lsb_elig_s) begin
      if (last_grant_r) begin
        grant_alu_s = 1'b1;
      end else begin
        grant_lsb_s = 1'b1;
      end
    end else if (alu_elig_s) begin
      grant_alu_s = 1'b1;
    end else if (lsb_elig_s) begin
      grant_lsb_s = 1'b1;
    end else begin
      grant_alu_s = 1'b0;
      grant_lsb_s = 1'b0;
    end
  end

  // Select the granted payload: FIFO head, or the live input when bypassing.
  always_comb begin
    sel_tag_s = alu_tag_mem_r[alu_rd_ptr_r];
    sel_val_s = alu_val_mem_r[alu_rd_ptr_r];
    if (grant_lsb_s) begin
      if (lsb_bp_s) begin
        sel_tag_s = lsb_rob_entry;
        sel_val_s = lsb_value;
      end else begin
        sel_tag_s = lsb_tag_mem_r[lsb_rd_ptr_r];
        sel_val_s = lsb_val_mem_r[lsb_rd_ptr_r];
      end
    end else begin
      if (alu_bp_s) begin
        sel_tag_s = alu_rob_entry;
        sel_val_s = alu_value;
      end else begin
        sel_tag_s = alu_tag_mem_r[alu_rd_ptr_r];
        sel_val_s = alu_val_mem_r[alu_rd_ptr_r];
      end
    end
  end

  // A granted bypass never touches the FIFO; a full FIFO drops the push even
  // if it is popped this same cycle.
  assign alu_push_s = alu_valid & ~alu_full & ~(alu_bp_s & grant_alu_s);
  assign lsb_push_s = lsb_valid & ~lsb_full & ~(lsb_bp_s & grant_lsb_s);
  assign alu_pop_s  = grant_alu_s & alu_nonempty_s;
  assign lsb_pop_s  = grant_lsb_s & lsb_nonempty_s;

  // FIFO payload storage; contents need no reset since counts gate visibility.
  always_ff @(posedge clk_in) begin
    if (advance_s && alu_push_s) begin
      alu_tag_mem_r[alu_wr_ptr_r] <= alu_rob_entry;
      alu_val_mem_r[alu_wr_ptr_r] <= alu_value;
    end
    if (advance_s && lsb_push_s) begin
      lsb_tag_mem_r[lsb_wr_ptr_r] <= lsb_rob_entry;
      lsb_val_mem_r[lsb_wr_ptr_r] <= lsb_value;
    end
  end

  // Pointers, counts, arbitration state and the registered CDB.
  always_ff @(posedge clk_in) begin
    if (!rst_in || rob_clear_up) begin
      alu_rd_ptr_r  <= PTR_ZERO;
      alu_wr_ptr_r  <= PTR_ZERO;
      lsb_rd_ptr_r  <= PTR_ZERO;
      lsb_wr_ptr_r  <= PTR_ZERO;
      alu_cnt_r     <= CNT_ZERO;
      lsb_cnt_r     <= CNT_ZERO;
      last_grant_r  <= 1'b1;
      cdb_valid     <= 1'b0;
      cdb_rob_entry <= ROB_W'(1'b0);
      cdb_value     <= 32'h0000_0000;
      cdb_src       <= 1'b0;
      // A flush is not an error-recovery event; only reset clears the flag.
      if (!rst_in) begin
        overflow_err <= 1'b0;
      end
    end else if (rdy_in) begin
      if (alu_push_s) alu_wr_ptr_r <= alu_wr_ptr_r + PTR_ONE;
      if (lsb_push_s) lsb_wr_ptr_r <= lsb_wr_ptr_r + PTR_ONE;
      if (alu_pop_s)  alu_rd_ptr_r <= alu_rd_ptr_r + PTR_ONE;
      if (lsb_pop_s)  lsb_rd_ptr_r <= lsb_rd_ptr_r + PTR_ONE;

      case ({alu_push_s, alu_pop_s})
        2'b10:   alu_cnt_r <= alu_cnt_r + CNT_ONE;
        2'b01:   alu_cnt_r <= alu_cnt_r - CNT_ONE;
        default: alu_cnt_r <= alu_cnt_r;
      endcase
      case ({lsb_push_s, lsb_pop_s})
        2'b10:   lsb_cnt_r <= lsb_cnt_r + CNT_ONE;
        2'b01:   lsb_cnt_r <= lsb_cnt_r - CNT_ONE;
        default: lsb_cnt_r <= lsb_cnt_r;
      endcase

      if ((alu_valid && alu_full) || (lsb_valid && lsb_full)) begin
        overflow_err <= 1'b1;
      end

      if (grant_alu_s || grant_lsb_s) begin
        cdb_valid     <= 1'b1;
        cdb_rob_entry <= sel_tag_s;
        cdb_value     <= sel_val_s;
        cdb_src       <= grant_lsb_s;
        // Remember every winner so alternation continues from the last user.
        last_grant_r  <= grant_lsb_s;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//   Directed stimulus for cdb_arbiter with a scoreboard: each issued push that
//   should reach the bus queues its expected {src, tag, value}; an independent
//   monitor pops and compares on every live broadcast edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear_up;
  logic        alu_valid;
  logic [3:0]  alu_rob_entry;
  logic [31:0] alu_value;
  logic        alu_full;
  logic        lsb_valid;
  logic [3:0]  lsb_rob_entry;
  logic [31:0] lsb_value;
  logic        lsb_full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_entry;
  logic [31:0] cdb_value;
  logic        cdb_src;
  logic        overflow_err;

  typedef struct packed {
    logic        src;
    logic [3:0]  tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_live;
  exp_t mon_e;
  exp_t mon_act;

  cdb_arbiter #(.ROB_W(4), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .rob_clear_up  (rob_clear_up),
    .alu_valid     (alu_valid),
    .alu_rob_entry (alu_rob_entry),
    .alu_value     (alu_value),
    .alu_full      (alu_full),
    .lsb_valid     (lsb_valid),
    .lsb_rob_entry (lsb_rob_entry),
    .lsb_value     (lsb_value),
    .lsb_full      (lsb_full),
    .cdb_valid     (cdb_valid),
    .cdb_rob_entry (cdb_rob_entry),
    .cdb_value     (cdb_value),
    .cdb_src       (cdb_src),
    .overflow_err  (overflow_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
  endtask

  // Present one cycle of pushes; queue expectations for those that will broadcast.
  task automatic drive(input logic av, input logic [3:0] at, input logic [31:0] avl,
                       input logic lv, input logic [3:0] lt, input logic [31:0] lvl,
                       input logic exp_a, input logic exp_l);
    alu_valid     = av;
    alu_rob_entry = at;
    alu_value     = avl;
    lsb_valid     = lv;
    lsb_rob_entry = lt;
    lsb_value     = lvl;
    if (av && exp_a) exp_q.push_back({1'b0, at, avl});
    if (lv && exp_l) exp_q.push_back({1'b1, lt, lvl});
  endtask

  task automatic do_reset();
    rst_in       = 1'b0;
    rob_clear_up = 1'b0;
    rdy_in       = 1'b1;
    idle();
    step();
    step();
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_tag",   32'(cdb_rob_entry), 32'd0);
    chk("rst_cdb_value", cdb_value, 32'd0);
    chk("rst_cdb_src",   32'(cdb_src), 32'd0);
    chk("rst_fulls",     32'({alu_full, lsb_full}), 32'd0);
    chk("rst_overflow",  32'(overflow_err), 32'd0);
    rst_in = 1'b1;
  endtask

  // Scoreboard monitor: a broadcast is new only on an edge that was live.
  always @(posedge clk_in) begin
    mon_live = rst_in && rdy_in && !rob_clear_up;
    #1;
    if (mon_live && cdb_valid) begin
      mon_act = {cdb_src, cdb_rob_entry, cdb_value};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got src %0d tag %0d value 0x%0h, expected no broadcast",
                 cdb_src, cdb_rob_entry, cdb_value);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (mon_act !== mon_e) begin
          errors++;
          $display("FAIL cdb_entry: got src %0d tag %0d value 0x%0h, expected src %0d tag %0d value 0x%0h",
                   mon_act.src, mon_act.tag, mon_act.val, mon_e.src, mon_e.tag, mon_e.val);
        end
      end
    end
  end

  initial begin
    int nv;
    alu_rob_entry = 4'd0;
    alu_value     = 32'd0;
    lsb_rob_entry = 4'd0;
    lsb_value     = 32'd0;
    do_reset();

    // Pushes while frozen are ignored.
    rdy_in = 1'b0;
    drive(1'b1, 4'd9, 32'h0000_0099, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    step();
    step();
    idle();
    rdy_in = 1'b1;
    repeat (3) step();
    chk("frozen_push_dropped", 32'(cdb_valid), 32'd0);

    // Single push: two-cycle latency, valid for one cycle.
    do_reset();
    drive(1'b1, 4'd3, 32'h1234_5678, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    step();
    idle();
    chk("single_E_valid", 32'(cdb_valid), 32'd0);
    step();
    chk("single_E1_valid", 32'(cdb_valid), 32'd1);
    chk("single_E1_tag", 32'(cdb_rob_entry), 32'd3);
    step();
    chk("single_E2_valid", 32'(cdb_valid), 32'd0);

    // Tie after reset: ALU first, then LSB.
    do_reset();
    drive(1'b1, 4'd1, 32'h0000_000A, 1'b1, 4'd2, 32'h0000_000B, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("tie_first_src", 32'(cdb_src), 32'd0);
    chk("tie_first_tag", 32'(cdb_rob_entry), 32'd1);
    step();
    chk("tie_second_src", 32'(cdb_src), 32'd1);
    chk("tie_second_tag", 32'(cdb_rob_entry), 32'd2);
    step();
    chk("tie_after_valid", 32'(cdb_valid), 32'd0);

    // Round-robin fill: 8 consecutive alternating broadcasts.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 4) drive(1'b1, 4'(k), 32'h100 + k, 1'b1, 4'(k + 4), 32'h200 + k, 1'b1, 1'b1);
      else idle();
      step();
      if (k >= 1) begin
        chk("rr_valid", 32'(cdb_valid), 32'd1);
        chk("rr_src", 32'(cdb_src), 32'((k - 1) % 2));
      end
    end
    step();
    chk("rr_after_valid", 32'(cdb_valid), 32'd0);

    // Stall hold: tag 5 on the bus, three frozen cycles, then tag 6.
    do_reset();
    drive(1'b1, 4'd5, 32'h0000_0055, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd6, 32'h0000_0066, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
    step();
    idle();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_valid", 32'(cdb_valid), 32'd1);
      chk("stall_tag", 32'(cdb_rob_entry), 32'd5);
    end
    rdy_in = 1'b1;
    step();
    chk("stall_resume_valid", 32'(cdb_valid), 32'd1);
    chk("stall_resume_tag", 32'(cdb_rob_entry), 32'd6);
    step();
    chk("stall_after_valid", 32'(cdb_valid), 32'd0);

    // Overflow: both sources saturate; LSB fills first, 7th LSB push dropped.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 4'(i), 32'hA000 + i, 1'b1, 4'(i + 8), 32'hB000 + i, 1'b1, (i < 6));
      step();
      if (i == 5) begin
        chk("ovf_lsb_full", 32'(lsb_full), 32'd1);
        chk("ovf_alu_not_full", 32'(alu_full), 32'd0);
        chk("ovf_not_yet", 32'(overflow_err), 32'd0);
      end
      if (i == 6) begin
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_alu_full", 32'(alu_full), 32'd1);
        chk("ovf_lsb_drained", 32'(lsb_full), 32'd0);
      end
    end
    idle();
    repeat (8) step();
    chk("ovf_all_drained", 32'(exp_q.size()), 32'd0);

    // A flush keeps the sticky error.
    rob_clear_up = 1'b1;
    step();
    rob_clear_up = 1'b0;
    chk("flush_keeps_ovf", 32'(overflow_err), 32'd1);

    // Flush with queued entries and a simultaneous push.
    drive(1'b1, 4'd1, 32'hC001, 1'b1, 4'd2, 32'hD002, 1'b1, 1'b0);
    step();
    drive(1'b1, 4'd3, 32'hC003, 1'b1, 4'd4, 32'hD004, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'd5, 32'hC005, 1'b1, 4'd6, 32'hD006, 1'b0, 1'b0);
    rob_clear_up = 1'b1;
    step();
    rob_clear_up = 1'b0;
    idle();
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    chk("flush_fulls", 32'({alu_full, lsb_full}), 32'd0);
    nv = 0;
    repeat (6) begin
      step();
      if (cdb_valid) nv++;
    end
    chk("flush_no_broadcast", 32'(nv), 32'd0);

    // Reset clears the sticky error.
    do_reset();
    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
